// File: rtl/chunk_adder_pkg.sv
// chunk_adder_pkg
//   Shared definitions for the serial chunk adder: the width of one adder
//   slice and the controller state encoding.
package chunk_adder_pkg;

   // Bits handled by the datapath slice per cycle.
   localparam int CHUNK_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chunk_add_state_t;

endpackage

// File: rtl/full_adder_3bit.sv
// full_adder_3bit
//   Purely combinational 3-bit adder slice with carry in and carry out.
// Ports
//   a, b  in   3  addends
//   cin   in   1  carry in
//   sum   out  3  a + b + cin, low 3 bits
//   cout  out  1  carry out of bit 2
module full_adder_3bit (
   input  logic [2:0] a,
   input  logic [2:0] b,
   input  logic       cin,
   output logic [2:0] sum,
   output logic       cout
);

   // The 4-bit target keeps the carry out of the 3-bit add.
   assign {cout, sum} = a + b + {2'b00, cin};

endmodule

// File: rtl/serial_chunk_adder_ctrl.sv
// serial_chunk_adder_ctrl
//   Adds two (3*NUM_CHUNKS)-bit operands plus a carry-in with a single 3-bit
//   adder slice, one chunk per cycle starting from the LSB chunk. The carry
//   ripples between cycles through a register.
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  operand set valid
//   in_ready   out  1  operand set can be accepted (IDLE and not in reset)
//   in_a       in   W  operand A
//   in_b       in   W  operand B
//   in_cin     in   1  carry into chunk 0
//   out_valid  out  1  result valid (DONE)
//   out_ready  in   1  consumer takes the result
//   out_sum    out  W  sum bits
//   out_cout   out  1  carry out of the top chunk
//   busy       out  1  operation in progress or result waiting
module serial_chunk_adder_ctrl
   import chunk_adder_pkg::*;
#(
   parameter int NUM_CHUNKS = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_a,
   input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_b,
   input  logic                          in_cin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CHUNK_W*NUM_CHUNKS-1:0] out_sum,
   output logic                          out_cout,
   output logic                          busy
);

   localparam int W     = CHUNK_W * NUM_CHUNKS;
   localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   chunk_add_state_t state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             carry_q, carry_d;

   logic [W-1:0]         a_shift;
   logic [W-1:0]         b_shift;
   logic [CHUNK_W-1:0]   slice_sum;
   logic                 slice_cout;

   // Bring the current chunk down to the bottom bits for the slice.
   assign a_shift = a_q >> (CHUNK_W * int'(idx_q));
   assign b_shift = b_q >> (CHUNK_W * int'(idx_q));

   full_adder_3bit u_slice (
      .a    (a_shift[CHUNK_W-1:0]),
      .b    (b_shift[CHUNK_W-1:0]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = slice_cout;
            for (int i = 0; i < NUM_CHUNKS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  sum_d[i*CHUNK_W +: CHUNK_W] = slice_sum;
               end
            end
            // Index parks on the last chunk instead of wrapping.
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   // Result outputs are forced to zero outside DONE so partial sums and stale
   // carries never appear on the output channel.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign out_sum   = (state_q == DONE) ? sum_q : '0;
   assign out_cout  = (state_q == DONE) ? carry_q : 1'b0;
   assign busy      = (state_q == RUN) || (state_q == DONE);

endmodule
